// File: rtl/vram_bank_arbiter_if.sv
// Bus bundle between CPU bus decode / PPU and the banked VRAM arbiter.
// The arbiter uses the slave modport; whoever drives CPU and video requests uses master.
interface vram_bank_arbiter_if #(
  parameter int NBANKS     = 2,
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int WBUF_DEPTH = 4
);
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  logic                 ce;
  logic                 lcd_on;
  logic [1:0]           lcd_mode;
  logic [BW-1:0]        cpu_bank;
  logic [AW-1:0]        cpu_addr;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic [DW-1:0]        cpu_di;
  logic [DW-1:0]        cpu_do;
  logic                 cpu_rd_valid;
  logic                 cpu_busy;
  logic [AW-1:0]        vid_addr;
  logic [NBANKS*DW-1:0] vid_do;
  logic [CW-1:0]        wbuf_count;
  logic                 wr_drop;

  modport slave (
    input  ce, lcd_on, lcd_mode, cpu_bank, cpu_addr, cpu_rd, cpu_wr, cpu_di, vid_addr,
    output cpu_do, cpu_rd_valid, cpu_busy, vid_do, wbuf_count, wr_drop
  );

  modport master (
    output ce, lcd_on, lcd_mode, cpu_bank, cpu_addr, cpu_rd, cpu_wr, cpu_di, vid_addr,
    input  cpu_do, cpu_rd_valid, cpu_busy, vid_do, wbuf_count, wr_drop
  );
endinterface

// File: rtl/vram_bank_arbiter.sv
// Banked VRAM with CPU/video arbitration. Video always reads all banks at vid_addr.
// The CPU is locked out during pixel transfer; its writes are then posted into a small
// FIFO that drains once video releases VRAM. A read that arrives while posted writes are
// still queued waits for the drain so that it observes the written data.
module vram_bank_arbiter #(
  parameter int NBANKS     = 2,
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic               clk_sys,
  input  logic               reset,
  vram_bank_arbiter_if.slave bus
);
  localparam int BW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int CW   = $clog2(WBUF_DEPTH + 1);
  localparam int PW   = $clog2(WBUF_DEPTH);
  localparam int MEMD = 1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RDPEND
  } state_t;

  logic [DW-1:0] mem [NBANKS][MEMD];

  state_t state_q, state_d;

  logic [BW-1:0] fifoBank_q [WBUF_DEPTH];
  logic [AW-1:0] fifoAddr_q [WBUF_DEPTH];
  logic [DW-1:0] fifoData_q [WBUF_DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic [BW-1:0] pendBank_q, pendBank_d;
  logic [AW-1:0] pendAddr_q, pendAddr_d;
  logic [DW-1:0] cpuDo_q, cpuDo_d;
  logic          rdValid_q, rdValid_d;
  logic          wrDrop_q, wrDrop_d;
  logic [NBANKS*DW-1:0] vidDo_q;

  logic lock, empty, full;
  logic push, pop, wrDirect, rdArray, rdBlank, rdDefer;
  logic [BW-1:0] rdBank;
  logic [AW-1:0] rdAddr;
  logic          memWe;
  logic [BW-1:0] memBank;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;

  function automatic logic bankOk(input logic [BW-1:0] b);
    return int'(b) < NBANKS;
  endfunction

  assign lock  = bus.lcd_on & (bus.lcd_mode == 2'd3);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(WBUF_DEPTH));

  // Classify the CPU request, pick the single array-port user and compute next state.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    pendBank_d = pendBank_q;
    pendAddr_d = pendAddr_q;
    cpuDo_d    = cpuDo_q;
    rdValid_d  = 1'b0;
    wrDrop_d   = 1'b0;
    push       = 1'b0;
    wrDirect   = 1'b0;
    rdArray    = 1'b0;
    rdBlank    = 1'b0;
    rdDefer    = 1'b0;
    rdBank     = bus.cpu_bank;
    rdAddr     = bus.cpu_addr;

    if (bus.cpu_wr) begin
      if (!lock && empty && state_q != RDPEND) begin
        wrDirect = 1'b1;
      end else if (!full) begin
        push = 1'b1;
      end else begin
        wrDrop_d = 1'b1;
      end
    end

    pop = !lock && !empty;

    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    case (state_q)
      RDPEND: begin
        rdBank = pendBank_q;
        rdAddr = pendAddr_q;
        if (lock) begin
          rdBlank = 1'b1;
          state_d = IDLE;
        end else if (empty) begin
          rdArray = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        if (bus.cpu_rd && !bus.cpu_wr) begin
          if (lock) begin
            rdBlank = 1'b1;
          end else if (empty) begin
            rdArray = 1'b1;
          end else begin
            rdDefer = 1'b1;
          end
        end
        if (rdDefer) begin
          state_d    = RDPEND;
          pendBank_d = bus.cpu_bank;
          pendAddr_d = bus.cpu_addr;
        end else if (state_q == IDLE) begin
          if (!lock && count_d != '0) begin
            state_d = DRAIN;
          end
        end else if (count_d == '0) begin
          state_d = IDLE;
        end
      end
    endcase

    if (rdBlank) begin
      cpuDo_d   = '1;
      rdValid_d = 1'b1;
    end else if (rdArray) begin
      cpuDo_d   = bankOk(rdBank) ? mem[rdBank][rdAddr] : '1;
      rdValid_d = 1'b1;
    end

    memWe   = wrDirect | pop;
    memBank = pop ? fifoBank_q[rdPtr_q] : bus.cpu_bank;
    memAddr = pop ? fifoAddr_q[rdPtr_q] : bus.cpu_addr;
    memData = pop ? fifoData_q[rdPtr_q] : bus.cpu_di;
  end

  // Control state, FIFO pointers and CPU-facing result registers; frozen while ce is low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      pendBank_q <= '0;
      pendAddr_q <= '0;
      cpuDo_q    <= '1;
      rdValid_q  <= 1'b0;
      wrDrop_q   <= 1'b0;
    end else if (bus.ce) begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      pendBank_q <= pendBank_d;
      pendAddr_q <= pendAddr_d;
      cpuDo_q    <= cpuDo_d;
      rdValid_q  <= rdValid_d;
      wrDrop_q   <= wrDrop_d;
    end
  end

  // Posted-write storage; entries need no reset because count/pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (!reset && bus.ce && push) begin
      fifoBank_q[wrPtr_q] <= bus.cpu_bank;
      fifoAddr_q[wrPtr_q] <= bus.cpu_addr;
      fifoData_q[wrPtr_q] <= bus.cpu_di;
    end
  end

  // The shared CPU-side array write; out-of-range banks are silently ignored.
  always_ff @(posedge clk_sys) begin
    if (!reset && bus.ce && memWe && bankOk(memBank)) begin
      mem[memBank][memAddr] <= memData;
    end
  end

  // Video fetch of every bank at vid_addr, one ce of latency, never stalled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vidDo_q <= '0;
    end else if (bus.ce) begin
      for (int k = 0; k < NBANKS; k++) begin
        vidDo_q[k*DW +: DW] <= mem[k][bus.vid_addr];
      end
    end
  end

  assign bus.cpu_do       = cpuDo_q;
  assign bus.cpu_rd_valid = rdValid_q;
  assign bus.cpu_busy     = (state_q == RDPEND);
  assign bus.vid_do       = vidDo_q;
  assign bus.wbuf_count   = count_q;
  assign bus.wr_drop      = wrDrop_q;
endmodule

// File: tb/tb_vram_bank_arbiter.sv
// Directed bench for vram_bank_arbiter: read results are predicted into a scoreboard
// queue when a read is issued and compared when cpu_rd_valid pulses.
module tb_vram_bank_arbiter;
  localparam int NBANKS     = 2;
  localparam int AW         = 13;
  localparam int DW         = 8;
  localparam int WBUF_DEPTH = 4;

  logic clk_sys = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [31:0] expQ[$];
  int   waited;

  always #5 clk_sys = ~clk_sys;

  vram_bank_arbiter_if #(.NBANKS(NBANKS), .AW(AW), .DW(DW), .WBUF_DEPTH(WBUF_DEPTH)) bus ();

  vram_bank_arbiter #(.NBANKS(NBANKS), .AW(AW), .DW(DW), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus.slave)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [0:0] bank,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.cpu_rd   = rd;
    bus.cpu_wr   = wr;
    bus.cpu_bank = bank;
    bus.cpu_addr = addr;
    bus.cpu_di   = data;
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic issueRead(input logic [0:0] bank, input logic [AW-1:0] addr, input logic [DW-1:0] expData);
    expQ.push_back(32'(expData));
    applyStimulus(1'b1, 1'b0, bank, addr, '0);
  endtask

  task automatic waitRead(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!bus.cpu_rd_valid && cycles < budget) begin
      tick();
      cycles++;
    end
    if (bus.cpu_rd_valid) begin
      checkOutput({tag, "_sb"}, 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        checkOutput(tag, 32'(bus.cpu_do), expQ.pop_front());
      end
      tick();
      checkOutput({tag, "_pulse"}, 32'(bus.cpu_rd_valid), 32'd0);
    end else begin
      checkOutput({tag, "_timeout"}, 32'(bus.cpu_rd_valid), 32'd1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.ce       = 1'b1;
    bus.lcd_on   = 1'b1;
    bus.lcd_mode = 2'd0;
    bus.cpu_bank = '0;
    bus.cpu_addr = '0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_di   = '0;
    bus.vid_addr = '0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_cpu_do", 32'(bus.cpu_do), 32'hFF);
    checkOutput("rst_valid", 32'(bus.cpu_rd_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.cpu_busy), 32'd0);
    checkOutput("rst_vid_do", 32'(bus.vid_do), 32'd0);
    checkOutput("rst_count", 32'(bus.wbuf_count), 32'd0);
    checkOutput("rst_drop", 32'(bus.wr_drop), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] direct write and read, lock low");
    applyStimulus(1'b0, 1'b1, 1'b0, 13'h0010, 8'h33);
    applyStimulus(1'b0, 1'b1, 1'b0, 13'h0004, 8'h44);
    applyStimulus(1'b0, 1'b1, 1'b1, 13'h0010, 8'h5A);
    checkOutput("t1_count", 32'(bus.wbuf_count), 32'd0);
    issueRead(1'b1, 13'h0010, 8'h5A);
    waitRead("t1_rd_b1", 8, waited);
    checkOutput("t1_latency", 32'(waited), 32'd0);
    issueRead(1'b0, 13'h0010, 8'h33);
    waitRead("t1_rd_b0", 8, waited);

    $display("[TB] lockout read and video port");
    bus.lcd_mode = 2'd3;
    bus.vid_addr = 13'h0010;
    tick();
    checkOutput("t2_vid_do", 32'(bus.vid_do), 32'h5A33);
    issueRead(1'b1, 13'h0010, 8'hFF);
    waitRead("t2_rd_locked", 8, waited);

    $display("[TB] posted writes fill and drop");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, AW'(i), 8'hA0 + 8'(i));
      checkOutput("t3_fill_count", 32'(bus.wbuf_count), (i < 4) ? 32'(i + 1) : 32'd4);
      checkOutput("t3_fill_drop", 32'(bus.wr_drop), (i == 4) ? 32'd1 : 32'd0);
    end
    bus.lcd_mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3_drain_count", 32'(bus.wbuf_count), 32'(3 - i));
    end
    checkOutput("t3_drop_clear", 32'(bus.wr_drop), 32'd0);
    for (int i = 0; i < 4; i++) begin
      issueRead(1'b0, AW'(i), 8'hA0 + 8'(i));
      waitRead("t3_rd_drained", 8, waited);
    end
    issueRead(1'b0, 13'h0004, 8'h44);
    waitRead("t3_rd_dropped", 8, waited);

    $display("[TB] read deferred behind posted write");
    bus.lcd_mode = 2'd3;
    applyStimulus(1'b0, 1'b1, 1'b0, 13'h0020, 8'h11);
    checkOutput("t4_count", 32'(bus.wbuf_count), 32'd1);
    bus.lcd_mode = 2'd0;
    issueRead(1'b0, 13'h0020, 8'h11);
    checkOutput("t4_busy", 32'(bus.cpu_busy), 32'd1);
    waitRead("t4_rd", 8, waited);
    checkOutput("t4_wait", 32'(waited), 32'd1);
    checkOutput("t4_busy_clear", 32'(bus.cpu_busy), 32'd0);

    $display("[TB] drain paused by lock");
    bus.lcd_mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 13'h0030 + AW'(i), 8'hC0 + 8'(i));
    end
    checkOutput("t5_full", 32'(bus.wbuf_count), 32'd4);
    bus.lcd_mode = 2'd0;
    tick();
    tick();
    checkOutput("t5_half", 32'(bus.wbuf_count), 32'd2);
    bus.lcd_mode = 2'd3;
    tick();
    checkOutput("t5_hold_a", 32'(bus.wbuf_count), 32'd2);
    tick();
    checkOutput("t5_hold_b", 32'(bus.wbuf_count), 32'd2);
    bus.lcd_mode = 2'd0;
    tick();
    checkOutput("t5_resume", 32'(bus.wbuf_count), 32'd1);
    tick();
    checkOutput("t5_empty", 32'(bus.wbuf_count), 32'd0);
    issueRead(1'b0, 13'h0033, 8'hC3);
    waitRead("t5_rd_last", 8, waited);
    issueRead(1'b0, 13'h0030, 8'hC0);
    waitRead("t5_rd_first", 8, waited);

    $display("[TB] simultaneous read and write, clock enable low");
    applyStimulus(1'b1, 1'b1, 1'b0, 13'h0050, 8'h99);
    checkOutput("rdwr_no_valid", 32'(bus.cpu_rd_valid), 32'd0);
    issueRead(1'b0, 13'h0050, 8'h99);
    waitRead("rdwr_rd", 8, waited);
    bus.ce       = 1'b0;
    bus.lcd_mode = 2'd3;
    applyStimulus(1'b0, 1'b1, 1'b0, 13'h0060, 8'h01);
    checkOutput("ce_low_count", 32'(bus.wbuf_count), 32'd0);
    bus.ce       = 1'b1;
    bus.lcd_mode = 2'd0;
    tick();

    $display("[TB] reset during drain with pending read");
    applyStimulus(1'b0, 1'b1, 1'b1, 13'h0041, 8'h78);
    bus.lcd_mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 13'h0040 + AW'(i), 8'hD0 + 8'(i));
    end
    bus.lcd_mode = 2'd0;
    applyStimulus(1'b1, 1'b0, 1'b1, 13'h0040, 8'h00);
    checkOutput("t6_count_pre", 32'(bus.wbuf_count), 32'd3);
    checkOutput("t6_busy_pre", 32'(bus.cpu_busy), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("t6_count_rst", 32'(bus.wbuf_count), 32'd0);
    checkOutput("t6_busy_rst", 32'(bus.cpu_busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t6_no_valid", 32'(bus.cpu_rd_valid), 32'd0);
      tick();
    end
    issueRead(1'b1, 13'h0040, 8'hD0);
    waitRead("t6_rd_drained", 8, waited);
    issueRead(1'b1, 13'h0041, 8'h78);
    waitRead("t6_rd_kept", 8, waited);
    issueRead(1'b1, 13'h0010, 8'h5A);
    waitRead("t6_rd_old", 8, waited);

    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
